wave_playback_ctrl: RTL

//  Sequencer between the SPI command word assembler and the waveform RAM/DAC FIFO.

---
 rtl/wave_playback_ctrl.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/wave_playback_ctrl.sv
// wave_playback_ctrl
// Sequencer between the SPI command assembler and the waveform RAM / DAC FIFO.
// Decodes 32-bit command words, loads samples into the single-port waveform
// RAM and streams the stored table into the DAC clock-crossing FIFO. The read
// path is a RD_LAT-deep valid shift register. Every issued read lands in the
// FIFO, so the almost-full threshold must leave at least RD_LAT+1 free entries.

module wave_playback_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 14,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              usrReset,
    input  logic              cmd_valid,
    input  logic [31:0]       cmd_word,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              fifo_almost_full,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_din,
    output logic              dac_enable,
    output logic              busy,
    output logic              cmd_err,
    output logic [7:0]        led_state
);

    localparam logic [3:0] OP_WRITE  = 4'd1;
    localparam logic [3:0] OP_SETLEN = 4'd2;
    localparam logic [3:0] OP_RUN    = 4'd3;
    localparam logic [3:0] OP_STOP   = 4'd4;

    localparam logic [ADDR_W:0] TBL_MAX = (ADDR_W+1)'(2**ADDR_W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    // A table length is usable only if it is non-zero and fits the RAM.
    function automatic logic len_ok(input logic [ADDR_W:0] len);
        return (len != '0) && (len <= TBL_MAX);
    endfunction

    state_t            state_q;
    state_t            state_d;

    logic [3:0]        opcode;
    logic [ADDR_W:0]   len_field;
    logic [ADDR_W-1:0] wr_addr_field;
    logic [DATA_W-1:0] wr_data_field;

    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [ADDR_W-1:0] addr_hold_q;
    logic [ADDR_W:0]   tbl_len_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [15:0]       rep_cnt_q;
    logic              rep_forever_q;

    // vld_p0 is the read issued this cycle; vld_p[k] is that read k cycles later.
    logic              vld_p0;
    logic [RD_LAT:1]   vld_p;
    logic              rd_pending;

    logic              wrap;
    logic              last_wrap;
    logic              wr_accept;
    logic              len_accept;
    logic              run_start;
    logic              err_d;
    logic              drain_done;

    logic              cmd_err_q;
    logic              dac_en_q;

    logic              unused_cmd_bits;

    assign opcode          = cmd_word[31:28];
    assign len_field       = cmd_word[ADDR_W:0];
    assign wr_addr_field   = cmd_word[14 +: ADDR_W];
    assign wr_data_field   = cmd_word[DATA_W-1:0];
    assign unused_cmd_bits = ^cmd_word;

    // Reads still travelling that will produce a FIFO write in a later cycle.
    always_comb begin
        rd_pending = 1'b0;
        for (int i = 1; i < RD_LAT; i++) begin
            rd_pending = rd_pending | vld_p[i];
        end
    end

    // Next-state logic and command decode.
    always_comb begin
        state_d    = state_q;
        wr_accept  = 1'b0;
        len_accept = 1'b0;
        run_start  = 1'b0;
        err_d      = 1'b0;
        drain_done = 1'b0;

        vld_p0    = (state_q == S_RUN) && !fifo_almost_full;
        wrap      = vld_p0 && ({1'b0, rd_ptr_q} == (tbl_len_q - 1'b1));
        last_wrap = wrap && !rep_forever_q && (rep_cnt_q == 16'd1);

        case (state_q)
            S_IDLE, S_LOAD: begin
                // LOAD lasts a single cycle; a command in that cycle is taken as in IDLE.
                if (state_q == S_LOAD) begin
                    state_d = S_IDLE;
                end
                if (cmd_valid) begin
                    case (opcode)
                        OP_WRITE: begin
                            wr_accept = 1'b1;
                            state_d   = S_LOAD;
                        end
                        OP_SETLEN: begin
                            if (len_ok(len_field)) begin
                                len_accept = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_RUN: begin
                            run_start = 1'b1;
                            state_d   = S_RUN;
                        end
                        OP_STOP: begin
                        end
                        default: begin
                            err_d = 1'b1;
                        end
                    endcase
                end
            end
            S_RUN: begin
                // STOP and the final wrap may coincide; both just lead to DRAIN.
                if (last_wrap) begin
                    state_d = S_DRAIN;
                end
                if (cmd_valid) begin
                    if (opcode == OP_STOP) begin
                        state_d = S_DRAIN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (!rd_pending) begin
                    state_d    = S_IDLE;
                    drain_done = 1'b1;
                end
                if (cmd_valid && (opcode != OP_STOP)) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge usrReset) begin
        if (usrReset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Captured WRITE address/data and the active table length.
    always_ff @(posedge clk or posedge usrReset) begin
        if (usrReset) begin
            wr_addr_q <= '0;
            wr_data_q <= '0;
            tbl_len_q <= TBL_MAX;
        end else begin
            if (wr_accept) begin
                wr_addr_q <= wr_addr_field;
                wr_data_q <= wr_data_field;
            end
            if (len_accept) begin
                tbl_len_q <= len_field;
            end
        end
    end

    // Read pointer with table wrap and the repeat counter.
    always_ff @(posedge clk or posedge usrReset) begin
        if (usrReset) begin
            rd_ptr_q      <= '0;
            rep_cnt_q     <= '0;
            rep_forever_q <= 1'b0;
        end else begin
            if (run_start) begin
                rd_ptr_q      <= '0;
                rep_cnt_q     <= cmd_word[15:0];
                rep_forever_q <= (cmd_word[15:0] == 16'd0);
            end else if (vld_p0) begin
                if (wrap) begin
                    rd_ptr_q <= '0;
                    if (!rep_forever_q) begin
                        rep_cnt_q <= rep_cnt_q - 16'd1;
                    end
                end else begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
            end
        end
    end

    // ---- stage boundary: RAM read latency, one valid bit per cycle of delay ----
    always_ff @(posedge clk or posedge usrReset) begin
        if (usrReset) begin
            vld_p <= '0;
        end else begin
            vld_p[1] <= vld_p0;
            for (int i = 2; i <= RD_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    // Reject pulse, DAC enable latch and the held RAM address.
    always_ff @(posedge clk or posedge usrReset) begin
        if (usrReset) begin
            cmd_err_q   <= 1'b0;
            dac_en_q    <= 1'b0;
            addr_hold_q <= '0;
        end else begin
            cmd_err_q   <= err_d;
            addr_hold_q <= mem_addr;
            if (drain_done) begin
                dac_en_q <= 1'b0;
            end else if (fifo_wr_en) begin
                dac_en_q <= 1'b1;
            end
        end
    end

    // RAM address: write address in LOAD, read pointer on issue, else hold.
    always_comb begin
        mem_addr = addr_hold_q;
        if (state_q == S_LOAD) begin
            mem_addr = wr_addr_q;
        end else if (vld_p0) begin
            mem_addr = rd_ptr_q;
        end
    end

    // Status LEDs follow the state encoding used on the front panel.
    always_comb begin
        case (state_q)
            S_IDLE:  led_state = 8'd1;
            S_LOAD:  led_state = 8'd2;
            S_RUN:   led_state = 8'd3;
            S_DRAIN: led_state = 8'd4;
            default: led_state = 8'd1;
        endcase
    end

    assign mem_we     = (state_q == S_LOAD);
    assign mem_din    = wr_data_q;
    assign fifo_wr_en = vld_p[RD_LAT];
    // Gated so the data bus is quiet (and zero in reset) between writes.
    assign fifo_din   = fifo_wr_en ? mem_dout : '0;
    assign dac_enable = dac_en_q;
    assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign cmd_err    = cmd_err_q;

endmodule
